// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
// Glitch counting is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_QUALIFY = 1'b1
   } state_t;

   localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain bringing an asynchronous bit into the clk domain.
module sync_chain #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= {STAGES{RESET_VAL}};
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], d};
      end
   end

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronizes and debounces a bouncing input; dout follows only levels held
// for DEBOUNCE_CYCLES samples. Optional macro: DEBOUNCE_GLITCH_CNT_EN.
module input_debounce
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    din,
   output logic                    dout,
   output logic                    busy,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("input_debounce: SYNC_STAGES must be in 2..4");
   end
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
      $error("input_debounce: DEBOUNCE_CYCLES must be in 2..65535");
   end

   logic             s;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             dout_reg, dout_next;

   sync_chain #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RESET_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_STABLE;
         cnt_reg   <= '0;
         dout_reg  <= RESET_LEVEL;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dout_reg  <= dout_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dout_next  = dout_reg;
      case (state_reg)
         ST_STABLE: begin
            if (s != dout_reg) begin
               state_next = ST_QUALIFY;
               cnt_next   = CNT_W'(1);
            end else begin
               cnt_next = '0;
            end
         end
         ST_QUALIFY: begin
            if (s == dout_reg) begin
               // Input bounced back before qualifying: drop it.
               state_next = ST_STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               dout_next  = s;
               state_next = ST_STABLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
      endcase
   end

   assign dout = dout_reg;
   assign busy = (state_reg == ST_QUALIFY);

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic                    glitch_evt;
   logic [GLITCH_CNT_W-1:0] glitch_reg;

   assign glitch_evt = (state_reg == ST_QUALIFY) && (s == dout_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_reg <= '0;
      end else if (glitch_evt && (glitch_reg != {GLITCH_CNT_W{1'b1}})) begin
         glitch_reg <= glitch_reg + GLITCH_CNT_W'(1);
      end
   end

   assign glitch_cnt = glitch_reg;
`else
   assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: latency, glitch rejection, reset abort,
// glitch counter saturation and a RESET_LEVEL=1 instance.
module tb_input_debounce;

   logic       clk = 1'b0;
   logic       rst, din, dout, busy;
   logic [7:0] glitch_cnt;
   logic       rst1, din1, dout1, busy1;
   logic [7:0] glitch_cnt1;

   int checks = 0;
   int errors = 0;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(1'b0)) dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout), .busy(busy), .glitch_cnt(glitch_cnt)
   );

   input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(1'b1)) dut1 (
      .clk(clk), .rst(rst1), .din(din1), .dout(dout1), .busy(busy1), .glitch_cnt(glitch_cnt1)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_gc(input int n);
      if (!GC_EN) return 8'h00;
      return (n > 255) ? 8'hFF : n[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Advance until dout reaches target; reports edge index and busy cycles.
   task automatic wait_dout(input logic target, input int limit,
                            output int edge_n, output int busy_n);
      edge_n = -1;
      busy_n = 0;
      for (int e = 1; e <= limit; e++) begin
         tick();
         if (busy) busy_n++;
         if (dout == target && edge_n < 0) edge_n = e;
      end
   endtask

   task automatic pulses(input int n);
      for (int p = 0; p < n; p++) begin
         din = 1'b1;
         repeat (3) tick();
         din = 1'b0;
         repeat (3) tick();
      end
   endtask

   task automatic test_reset();
      din = 1'b1;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dout !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: dout=%b busy=%b glitch=%0d, want 0 0 0", dout, busy, glitch_cnt);
      end
      do_reset();
      $display("test_reset: dout=%b busy=%b glitch=%0d", dout, busy, glitch_cnt);
   endtask

   task automatic test_rise_fall();
      int edge_n, busy_n;
      do_reset();
      din = 1'b1;
      wait_dout(1'b1, 30, edge_n, busy_n);
      checks++;
      if (edge_n != 18) begin
         errors++;
         $display("FAIL rise_latency: got %0d edges, want 18", edge_n);
      end
      checks++;
      if (busy_n != 15) begin
         errors++;
         $display("FAIL rise_busy: got %0d cycles, want 15", busy_n);
      end
      checks++;
      if (glitch_cnt !== 8'h00) begin
         errors++;
         $display("FAIL rise_glitch: got %0d, want 0", glitch_cnt);
      end
      $display("test_rise: latency=%0d busy_cycles=%0d glitch=%0d", edge_n, busy_n, glitch_cnt);
      din = 1'b0;
      wait_dout(1'b0, 30, edge_n, busy_n);
      checks++;
      if (edge_n != 18) begin
         errors++;
         $display("FAIL fall_latency: got %0d edges, want 18", edge_n);
      end
      $display("test_back_to_back: fall latency=%0d", edge_n);
   endtask

   task automatic test_glitch();
      int high_seen = 0;
      do_reset();
      din = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dout) high_seen++;
      end
      din = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (dout) high_seen++;
      end
      checks++;
      if (high_seen != 0) begin
         errors++;
         $display("FAIL glitch_dout: dout high %0d cycles, want 0", high_seen);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy: got %b, want 0", busy);
      end
      checks++;
      if (glitch_cnt !== exp_gc(1)) begin
         errors++;
         $display("FAIL glitch_cnt_one: got %0d, want %0d", glitch_cnt, exp_gc(1));
      end
      $display("test_glitch: dout_high=%0d busy=%b glitch=%0d", high_seen, busy, glitch_cnt);
   endtask

   task automatic test_bursts();
      int edge_n, busy_n;
      do_reset();
      pulses(5);
      checks++;
      if (dout !== 1'b0 || glitch_cnt !== exp_gc(5)) begin
         errors++;
         $display("FAIL bursts_glitch: dout=%b glitch=%0d, want 0 %0d", dout, glitch_cnt, exp_gc(5));
      end
      din = 1'b1;
      wait_dout(1'b1, 30, edge_n, busy_n);
      checks++;
      if (edge_n != 18) begin
         errors++;
         $display("FAIL bursts_latency: got %0d edges, want 18", edge_n);
      end
      $display("test_bursts: glitch=%0d latency=%0d", glitch_cnt, edge_n);
   endtask

   task automatic test_reset_mid();
      int edge_n, busy_n;
      do_reset();
      pulses(1);
      din = 1'b1;
      repeat (10) tick();
      checks++;
      if (busy !== 1'b1 || dout !== 1'b0) begin
         errors++;
         $display("FAIL mid_qualify: busy=%b dout=%b, want 1 0", busy, dout);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dout !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: dout=%b busy=%b glitch=%0d, want 0 0 0", dout, busy, glitch_cnt);
      end
      tick();
      rst = 1'b0;
      wait_dout(1'b1, 30, edge_n, busy_n);
      checks++;
      if (edge_n != 18 || glitch_cnt !== 8'h00) begin
         errors++;
         $display("FAIL mid_requalify: latency=%0d glitch=%0d, want 18 0", edge_n, glitch_cnt);
      end
      $display("test_reset_mid: requalify latency=%0d glitch=%0d", edge_n, glitch_cnt);
   endtask

   task automatic test_saturate();
      int high_seen = 0;
      do_reset();
      for (int p = 0; p < 300; p++) begin
         pulses(1);
         if (dout) high_seen++;
      end
      checks++;
      if (glitch_cnt !== exp_gc(300)) begin
         errors++;
         $display("FAIL saturate: got %0h, want %0h", glitch_cnt, exp_gc(300));
      end
      checks++;
      if (high_seen != 0) begin
         errors++;
         $display("FAIL saturate_dout: dout high at %0d samples, want 0", high_seen);
      end
      $display("test_saturate: glitch=%0h", glitch_cnt);
   endtask

   task automatic test_level1();
      int busy_seen = 0;
      int low_seen = 0;
      din1 = 1'b1;
      rst1 = 1'b1;
      #1;
      checks++;
      if (dout1 !== 1'b1 || busy1 !== 1'b0 || glitch_cnt1 !== 8'h00) begin
         errors++;
         $display("FAIL level1_reset: dout=%b busy=%b glitch=%0d, want 1 0 0", dout1, busy1, glitch_cnt1);
      end
      tick();
      rst1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy1) busy_seen++;
         if (!dout1) low_seen++;
      end
      checks++;
      if (busy_seen != 0 || low_seen != 0) begin
         errors++;
         $display("FAIL level1_hold: busy %0d cycles, dout low %0d cycles, want 0 0", busy_seen, low_seen);
      end
      $display("test_level1: dout=%b busy_cycles=%0d", dout1, busy_seen);
   endtask

   initial begin
      rst  = 1'b1;
      din  = 1'b0;
      rst1 = 1'b1;
      din1 = 1'b1;
      do_reset();
      test_reset();
      test_rise_fall();
      test_glitch();
      test_bursts();
      test_reset_mid();
      test_saturate();
      test_level1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
